// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between the CPU and an aux master.
// Optional: define DMEM_ARB_TIMEOUT_EN for a bounded wait with a sticky timeout_err output.
module dmem_arbiter #(
   parameter int ADDR_W         = 14,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [31:0]       c_wdata,
   input  logic [3:0]        c_sign_mask,
   output logic              c_ack,
   output logic [31:0]       c_rdata,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [31:0]       a_wdata,
   input  logic [3:0]        a_sign_mask,
   output logic              a_ack,
   output logic [31:0]       a_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_write_data,
   output logic              mem_memread,
   output logic              mem_memwrite,
   output logic [3:0]        mem_sign_mask,
   input  logic [31:0]       mem_read_data,
   input  logic              mem_clk_stall,
   output logic              busy,
   output logic              grant_id
`ifdef DMEM_ARB_TIMEOUT_EN
   ,
   output logic              timeout_err
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_HI,
      S_WAIT_LO,
      S_RESP
   } state_t;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_t            r_state;
   logic              r_last;
   logic              r_grant;
   logic              r_busy;
   logic              r_c_ack;
   logic              r_a_ack;
   logic              r_memread;
   logic              r_memwrite;
   logic [31:0]       r_c_rdata;
   logic [31:0]       r_a_rdata;
   logic [31:0]       r_wdata;
   logic [ADDR_W-1:0] r_addr;
   logic [3:0]        r_mask;

   logic              w_any;
   logic              w_pick_aux;
   logic              w_grant;
   logic              w_done_ok;
   logic              w_timeout;
   logic              w_finish;
   logic [31:0]       w_resp_data;

   // On a tie the requester that did not win last time is served.
   assign w_any       = c_req | a_req;
   assign w_pick_aux  = (c_req && a_req) ? ~r_last : a_req;
   assign w_grant     = (r_state == S_IDLE) && w_any && !mem_clk_stall;
   assign w_done_ok   = (r_state == S_WAIT_LO) && !mem_clk_stall;
   assign w_finish    = w_done_ok | w_timeout;
   assign w_resp_data = w_timeout ? 32'hDEADBEEF : mem_read_data;

`ifdef DMEM_ARB_TIMEOUT_EN
   localparam int            TW      = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] r_tcnt;
   logic          r_timeout_err;

   assign w_timeout   = ((r_state == S_WAIT_HI) || (r_state == S_WAIT_LO)) &&
                        !w_done_ok && (r_tcnt == TO_LAST);
   assign timeout_err = r_timeout_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tcnt        <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         if (w_grant)
            r_tcnt <= '0;
         else if ((r_state == S_WAIT_HI) || (r_state == S_WAIT_LO))
            r_tcnt <= r_tcnt + 1'b1;
         if (w_timeout)
            r_timeout_err <= 1'b1;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_last     <= 1'b1;
         r_grant    <= 1'b0;
         r_busy     <= 1'b0;
         r_c_ack    <= 1'b0;
         r_a_ack    <= 1'b0;
         r_memread  <= 1'b0;
         r_memwrite <= 1'b0;
         r_c_rdata  <= '0;
         r_a_rdata  <= '0;
         r_wdata    <= '0;
         r_addr     <= '0;
         r_mask     <= '0;
      end else begin
         r_memread  <= 1'b0;
         r_memwrite <= 1'b0;
         r_c_ack    <= 1'b0;
         r_a_ack    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_state <= S_ISSUE;
                  r_busy  <= 1'b1;
                  r_grant <= w_pick_aux;
                  r_last  <= w_pick_aux;
                  if (w_pick_aux) begin
                     r_addr     <= a_addr;
                     r_wdata    <= a_wdata;
                     r_mask     <= a_sign_mask;
                     r_memwrite <= a_we;
                     r_memread  <= ~a_we;
                  end else begin
                     r_addr     <= c_addr;
                     r_wdata    <= c_wdata;
                     r_mask     <= c_sign_mask;
                     r_memwrite <= c_we;
                     r_memread  <= ~c_we;
                  end
               end
            end
            S_ISSUE: r_state <= S_WAIT_HI;
            // Memory signals completion by a stall rise followed by its fall.
            S_WAIT_HI, S_WAIT_LO: begin
               if (w_finish) begin
                  r_state <= S_RESP;
                  if (r_grant) begin
                     r_a_ack   <= 1'b1;
                     r_a_rdata <= w_resp_data;
                  end else begin
                     r_c_ack   <= 1'b1;
                     r_c_rdata <= w_resp_data;
                  end
               end else if (mem_clk_stall) begin
                  r_state <= S_WAIT_LO;
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign c_ack          = r_c_ack;
   assign a_ack          = r_a_ack;
   assign c_rdata        = r_c_rdata;
   assign a_rdata        = r_a_rdata;
   assign mem_addr       = r_addr;
   assign mem_write_data = r_wdata;
   assign mem_sign_mask  = r_mask;
   assign mem_memread    = r_memread;
   assign mem_memwrite   = r_memwrite;
   assign busy           = r_busy;
   assign grant_id       = r_grant;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural stall-handshake memory plus a round-robin/latency reference model.
// Timeout checks are compiled in when DMEM_ARB_TIMEOUT_EN is defined.
module tb_dmem_arbiter;

   localparam int ADDR_W = 14;
   localparam int TO     = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              c_req, c_we, a_req, a_we;
   logic [ADDR_W-1:0] c_addr, a_addr;
   logic [31:0]       c_wdata, a_wdata;
   logic [3:0]        c_sign_mask, a_sign_mask;
   logic              c_ack, a_ack;
   logic [31:0]       c_rdata, a_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_write_data;
   logic              mem_memread, mem_memwrite;
   logic [3:0]        mem_sign_mask;
   logic [31:0]       mem_read_data;
   logic              mem_clk_stall;
   logic              busy, grant_id;
`ifdef DMEM_ARB_TIMEOUT_EN
   logic              timeout_err;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   dmem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_sign_mask(c_sign_mask), .c_ack(c_ack), .c_rdata(c_rdata),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_sign_mask(a_sign_mask), .a_ack(a_ack), .a_rdata(a_rdata),
      .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
      .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data),
      .mem_clk_stall(mem_clk_stall), .busy(busy), .grant_id(grant_id)
`ifdef DMEM_ARB_TIMEOUT_EN
      , .timeout_err(timeout_err)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Memory contents before any write: one fixed word, the rest a hash of the address.
   function automatic logic [31:0] init_word(input logic [ADDR_W-1:0] a);
      if (a == 14'h1004) return 32'h12345678;
      return 32'h9E3779B9 * {18'd0, a} + 32'h00001234;
   endfunction

   // Data memory model: a strobe latches the access and raises stall for stall_len cycles.
   int          stall_len = 2;
   int          scnt = 0;
   logic [31:0] rd_q = '0;
   logic [31:0] wmem [0:(1<<ADDR_W)-1];
   bit          wrote [0:(1<<ADDR_W)-1];

   always @(posedge clk) begin
      if (mem_memwrite) begin
         wmem[mem_addr]  <= mem_write_data;
         wrote[mem_addr] <= 1'b1;
         rd_q            <= mem_write_data;
         scnt            <= stall_len;
      end else if (mem_memread) begin
         rd_q <= wrote[mem_addr] ? wmem[mem_addr] : init_word(mem_addr);
         scnt <= stall_len;
      end else if (scnt > 0) begin
         scnt <= scnt - 1;
      end
   end
   assign mem_clk_stall = (scnt != 0);
   assign mem_read_data = rd_q;

   // Reference state: expected memory image and round-robin history.
   logic [31:0]       ref_mem [int];
   bit                last;
   bit                f_we   [2];
   logic [ADDR_W-1:0] f_addr [2];
   logic [31:0]       f_wd   [2];
   logic [3:0]        f_msk  [2];

   function automatic logic [31:0] ref_read(input logic [ADDR_W-1:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
   endfunction

   function automatic bit pick(input bit cr, input bit ar, input bit lst);
      if (cr && ar) return !lst;
      return ar;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic gen(input int r);
      f_we[r]   = 1'($urandom % 2);
      f_addr[r] = 14'h0200 + 14'($urandom_range(0, 31));
      f_wd[r]   = $urandom;
      f_msk[r]  = 4'($urandom);
   endtask

   task automatic drive(input bit cr, input bit ar);
      c_req = cr; c_we = f_we[0]; c_addr = f_addr[0]; c_wdata = f_wd[0]; c_sign_mask = f_msk[0];
      a_req = ar; a_we = f_we[1]; a_addr = f_addr[1]; a_wdata = f_wd[1]; a_sign_mask = f_msk[1];
   endtask

   // Called in the IDLE cycle where the request is first sampled (cycle 0); returns in the ack cycle.
   task automatic txn(input string nm, input bit aux, input int lat, input bit we,
                      input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                      input logic [3:0] msk, input logic [31:0] rd);
      int          strobes = 0;
      int          ackcyc  = -1;
      int          other   = 0;
      logic [31:0] other_rd0;
      other_rd0 = aux ? c_rdata : a_rdata;
      chk({nm, " busy_idle"}, busy, 1'b0);
      for (int cyc = 1; cyc <= lat + 4 && ackcyc < 0; cyc++) begin
         tick();
         if (mem_memread || mem_memwrite) begin
            strobes++;
            if (cyc == 1) begin
               chk({nm, " strobe_dir"}, {mem_memwrite, mem_memread}, we ? 2'b10 : 2'b01);
               chk({nm, " mem_addr"}, mem_addr, addr);
               chk({nm, " mem_mask"}, mem_sign_mask, msk);
               if (we) chk({nm, " mem_wdata"}, mem_write_data, wd);
               chk({nm, " grant_issue"}, grant_id, aux);
            end
         end
         if (aux ? c_ack : a_ack) other++;
         if (aux ? a_ack : c_ack) ackcyc = cyc;
      end
      chk({nm, " ack_cycle"}, ackcyc, lat);
      chk({nm, " strobes"}, strobes, 1);
      chk({nm, " other_ack"}, other, 0);
      chk({nm, " busy_resp"}, busy, 1'b1);
      chk({nm, " other_rdata"}, aux ? c_rdata : a_rdata, other_rd0);
      if (!we) chk({nm, " rdata"}, aux ? a_rdata : c_rdata, rd);
      if (we) ref_mem[int'(addr)] = wd;
   endtask

   initial begin
      bit pend [2];
      bit w;
      int r;

      reset = 1'b1;
      f_we = '{0, 0}; f_addr = '{0, 0}; f_wd = '{0, 0}; f_msk = '{0, 0};
      drive(0, 0);
      tick(); tick();
      chk("rst c_ack", c_ack, 0);
      chk("rst a_ack", a_ack, 0);
      chk("rst strobes", {mem_memread, mem_memwrite}, 0);
      chk("rst busy", busy, 0);
      chk("rst grant_id", grant_id, 0);
      chk("rst c_rdata", c_rdata, 0);
      chk("rst a_rdata", a_rdata, 0);
      chk("rst mem_addr", mem_addr, 0);
      chk("rst mem_wdata", mem_write_data, 0);
      chk("rst mem_mask", mem_sign_mask, 0);
`ifdef DMEM_ARB_TIMEOUT_EN
      chk("rst timeout_err", timeout_err, 0);
`endif
      reset = 1'b0;
      last  = 1'b1;

      // CPU read of the preset word.
      f_we[0] = 1'b0; f_addr[0] = 14'h1004; f_wd[0] = $urandom; f_msk[0] = 4'b1111;
      drive(1, 0);
      txn("cpu_rd", 0, 5, 0, 14'h1004, f_wd[0], 4'b1111, 32'h12345678);
      last = 0;
      drive(0, 0);
      tick();

      // Aux write.
      f_we[1] = 1'b1; f_addr[1] = 14'h1010; f_wd[1] = 32'hCAFEF00D; f_msk[1] = 4'b0111;
      drive(0, 1);
      txn("aux_wr", 1, 5, 1, 14'h1010, 32'hCAFEF00D, 4'b0111, 32'h0);
      last = 1;
      drive(0, 0);
      tick();
      chk("hold mem_addr", mem_addr, 14'h1010);
      chk("hold mem_wdata", mem_write_data, 32'hCAFEF00D);

      // Both requesting continuously from reset: grants must alternate.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      last  = 1'b1;
      gen(0); gen(1);
      drive(1, 1);
      for (int k = 0; k < 4; k++) begin
         w = pick(1, 1, last);
         txn($sformatf("rr%0d", k), w, 5, f_we[w], f_addr[w], f_wd[w], f_msk[w], ref_read(f_addr[w]));
         last = w;
         gen(int'(w));
         drive(1, 1);
         if (k == 3) drive(0, 0);
         tick();
      end

      // Random traffic with random stall lengths.
      pend = '{0, 0};
      for (int it = 0; it < 24; it++) begin
         if (!pend[0] && !pend[1]) begin
            r = $urandom % 3;
            pend[0] = (r != 1);
            pend[1] = (r != 0);
            if (pend[0]) gen(0);
            if (pend[1]) gen(1);
         end
         stall_len = $urandom_range(1, 4);
         drive(pend[0], pend[1]);
         w = pick(pend[0], pend[1], last);
         txn($sformatf("rnd%0d", it), w, 3 + stall_len, f_we[w], f_addr[w], f_wd[w], f_msk[w],
             ref_read(f_addr[w]));
         last = w;
         pend[w] = 1'($urandom % 2);
         if (pend[w]) gen(int'(w));
         drive(pend[0], pend[1]);
         tick();
      end
      drive(0, 0);
      tick();

      // Long stall: single strobe, ack one cycle after stall falls.
      stall_len = 10;
      gen(0); f_we[0] = 1'b0;
      drive(1, 0);
      txn("long_stall", 0, 13, 0, f_addr[0], f_wd[0], f_msk[0], ref_read(f_addr[0]));
      last = 0;
      drive(0, 0);
      tick();

      // Reset while waiting for stall to fall; memory keeps stalling afterwards.
      stall_len = 4;
      gen(0); f_we[0] = 1'b0;
      drive(1, 0);
      tick(); tick(); tick();
      chk("abort busy_wait", busy, 1);
      reset = 1'b1;
      tick();
      chk("abort busy", busy, 0);
      chk("abort c_ack", c_ack, 0);
      chk("abort strobes", {mem_memread, mem_memwrite}, 0);
      chk("abort c_rdata", c_rdata, 0);
      chk("abort mem_addr", mem_addr, 0);
      reset = 1'b0;
      last  = 1'b1;
      gen(0);
      drive(1, 0);
      tick();
      chk("abort stall_hold1", busy, 0);
      chk("abort no_ack", c_ack, 0);
      tick();
      chk("abort stall_hold2", busy, 0);
      txn("after_abort", 0, 3 + stall_len, f_we[0], f_addr[0], f_wd[0], f_msk[0], ref_read(f_addr[0]));
      last = 0;
      drive(0, 0);
      tick();

`ifdef DMEM_ARB_TIMEOUT_EN
      // Memory never stalls: forced completion after the timeout.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      last  = 1'b1;
      stall_len = 0;
      gen(0); f_we[0] = 1'b0;
      drive(1, 0);
      txn("timeout", 0, 2 + TO, 0, f_addr[0], f_wd[0], f_msk[0], 32'hDEADBEEF);
      drive(0, 0);
      chk("timeout_err set", timeout_err, 1);
      tick(); tick();
      chk("timeout_err sticky", timeout_err, 1);
      reset = 1'b1;
      tick();
      chk("timeout_err cleared", timeout_err, 0);
      reset = 1'b0;
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter that shares the single-ported data memory between the CPU load/store path and an auxiliary master (debug or DMA loader).
- Each requester has a req/ack handshake.
- The arbiter issues a one-cycle memread/memwrite strobe to the data memory, then tracks its clk_stall rise and fall.
- It returns read data and an ack pulse to the granted requester only.
- Sits between the processor/aux masters and the data memory; sharing is round-robin.

Parameters:
ADDR_W, 14, address width on all ports (matches data memory addr).
TIMEOUT_CYCLES, 16, max cycles in a wait state before forced completion (used only with the optional feature).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
c_req  in  1  CPU request; held until c_ack
c_we  in  1  CPU: 1 = write, 0 = read
c_addr  in  ADDR_W  CPU byte address
c_wdata  in  32  CPU write data
c_sign_mask  in  4  CPU size/sign mask, passed to memory unchanged
c_ack  out  1  one-cycle completion pulse to CPU
c_rdata  out  32  CPU read data, valid while c_ack=1
a_req, a_we, a_addr, a_wdata, a_sign_mask  in  same as CPU  auxiliary requester
a_ack  out  1  one-cycle completion pulse to aux
a_rdata  out  32  aux read data, valid while a_ack=1
mem_addr  out  ADDR_W  to data memory addr
mem_write_data  out  32  to data memory write_data
mem_memread  out  1  one-cycle read strobe
mem_memwrite  out  1  one-cycle write strobe
mem_sign_mask  out  4  to data memory sign_mask
mem_read_data  in  32  from data memory read_data
mem_clk_stall  in  1  from data memory clk_stall
busy  out  1  high in any state other than IDLE
grant_id  out  1  0 = CPU, 1 = aux; valid while busy

Behaviour:
- One clock domain. Synchronous, active-high reset named reset. Clock named clk.
- Reset values:
  - All acks, mem strobes and busy are 0.
  - rdata outputs are 0; mem_addr, mem_write_data and mem_sign_mask are 0.
  - grant_id is 0; last_grant is 1, so the CPU wins the first tie.
  - State is IDLE.
- States: IDLE, ISSUE, WAIT_HI, WAIT_LO, RESP.
- IDLE:
  - If any req=1 and mem_clk_stall=0, grant and go to ISSUE. Register the winner's addr, wdata, we and sign_mask onto the mem_* buses.
  - If mem_clk_stall=1 (memory still busy, e.g. after a reset mid-operation, since the memory has no reset), do not grant.
- Arbitration: only one req → that requester. Both → the one not equal to last_grant. last_grant updates on grant.
- ISSUE: exactly one of mem_memread/mem_memwrite is 1 for this single cycle. Next state WAIT_HI. Strobes are 0 in every other state.
- WAIT_HI: wait for mem_clk_stall=1, then go to WAIT_LO.
- WAIT_LO: wait for mem_clk_stall=0. On that cycle, capture mem_read_data into the granted rdata output and go to RESP.
- RESP: granted ack=1 for one cycle; next state IDLE.
  - The non-granted ack stays 0 and its rdata is unchanged.
  - For writes, rdata still updates with mem_read_data; its value is don't-care to the requester.
- Latency: req sampled in IDLE at cycle 0 → ack during cycle 5, for both reads and writes. A back-to-back request is sampled in the cycle after RESP.
- Requesters must hold req and all fields stable until ack, and drop req the cycle after ack unless issuing a new request.
- mem_* address, data and mask hold their values from grant until the next grant.
- Reset mid-operation: return to IDLE on the next edge, all outputs to reset values, no ack for the aborted access.
- A requester that drops req while granted is ignored. The access completes and ack still pulses.

Optional Feature:
DMEM_ARB_TIMEOUT_EN:
- When defined:
  - A counter runs in WAIT_HI/WAIT_LO and clears on entry to ISSUE.
  - On reaching TIMEOUT_CYCLES, go to RESP with rdata=32'hDEADBEEF.
  - Set output timeout_err (1 bit, sticky until reset, reset 0).
- When undefined: no counter, no timeout_err port, waits are unbounded.

Test Plan:
- CPU read, addr 14'h1004, memory model returns 32'h12345678 → mem_memread one cycle in cycle 1, c_ack in cycle 5 with c_rdata=32'h12345678, a_ack=0 throughout.
- Aux write, addr 14'h1010, wdata 32'hCAFEF00D, sign_mask 4'b0111 → one mem_memwrite pulse, mem_* fields match, a_ack in cycle 5, c_ack=0.
- c_req and a_req both asserted from reset for 4 transactions → grants in order CPU, aux, CPU, aux; grant_id toggles; each ack pulses once.
- Reset asserted in WAIT_LO, with memory stall still high for 2 more cycles → no ack, busy=0 next cycle; a new c_req is not granted until mem_clk_stall=0, then completes normally.
- CPU read with a memory model that holds mem_clk_stall high for 10 cycles → no strobe re-issue; c_ack 1 cycle after stall falls; no second memread.
- With DMEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, model never raises stall → ack after timeout with rdata 32'hDEADBEEF, timeout_err=1 until reset.
